mdu_iter: RTL and testbench

//  Parametrised iterative multiply/divide unit feeding the HI/LO registers of the MIPS pipeline.

---
 rtl/mdu_pkg.sv | 11 +
 rtl/mdu_sign_unit.sv | 27 ++
 rtl/mdu_iter.sv | 96 +++++++++
 tb/tb_mdu_iter.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared state encoding, op codes and sizing helper for the iterative multiply/divide unit
package mdu_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} stateT;
  localparam logic MDU_MUL = 1'b0;
  localparam logic MDU_DIV = 1'b1;
  function automatic int clog2(input int v);
    int r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction
endpackage

// File: rtl/mdu_sign_unit.sv
// mdu_sign_unit: operand magnitudes on entry and sign correction of the unsigned core result on exit
module mdu_sign_unit import mdu_pkg::*; #(
  parameter int W = 32
) (
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic           sign,
  output logic [W-1:0]   aMag,
  output logic [W-1:0]   bMag,
  output logic           aNeg,
  output logic           bNeg,
  input  logic           op,
  input  logic           negRes,
  input  logic           negRem,
  input  logic [2*W-1:0] res,
  output logic [W-1:0]   hi,
  output logic [W-1:0]   lo
);
  logic [2*W-1:0] prod;
  assign aNeg = sign & a[W-1];
  assign bNeg = sign & b[W-1];
  assign aMag = aNeg ? -a : a;
  assign bMag = bNeg ? -b : b;
  assign prod = negRes ? -res : res;
  assign lo = (op == MDU_DIV) ? (negRes ? -res[W-1:0] : res[W-1:0]) : prod[W-1:0];
  assign hi = (op == MDU_DIV) ? (negRem ? -res[2*W-1:W] : res[2*W-1:W]) : prod[2*W-1:W];
endmodule

// File: rtl/mdu_iter.sv
// mdu_iter: iterative multiply/divide unit producing HI/LO with stall, flush and divide-by-zero flag
module mdu_iter import mdu_pkg::*; #(
  parameter int WIDTH    = 32,
  parameter bit FAST_MUL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             op_i,
  input  logic             sign_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cancel_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             dbz_o
);
  localparam int CW = clog2(WIDTH);
  stateT state;
  logic [CW-1:0] cnt;
  logic [2*WIDTH:0] pr, prNext, divShift;
  logic [2*WIDTH-1:0] fastProd;
  logic [WIDTH:0] mulSum, divTrial;
  logic [WIDTH-1:0] aMagIn, bMagIn, aMagR, bMagR, aOrig, hiRes, loRes;
  logic opR, negRes, negRem, aNegIn, bNegIn, accept, lastStep, dbzNow;

  assign accept   = start_i & ~cancel_i & (state != RUN);
  assign busy_o   = (state == RUN) | accept;
  assign lastStep = (FAST_MUL && opR == MDU_MUL) || cnt == CW'(WIDTH - 1);
  assign dbzNow   = (opR == MDU_DIV) && (bMagR == '0);

  mdu_sign_unit #(.W(WIDTH)) signUnit (
    .a(a_i), .b(b_i), .sign(sign_i), .aMag(aMagIn), .bMag(bMagIn), .aNeg(aNegIn), .bNeg(bNegIn),
    .op(opR), .negRes(negRes), .negRem(negRem), .res(prNext[2*WIDTH-1:0]), .hi(hiRes), .lo(loRes)
  );

  // one datapath step: shift-add multiply or restoring divide (the shifted-out bit forces a subtract)
  always_comb begin
    fastProd = aMagR * bMagR;
    mulSum   = {1'b0, pr[2*WIDTH-1:WIDTH]} + {1'b0, {WIDTH{pr[0]}} & aMagR};
    divShift = {pr[2*WIDTH-1:0], 1'b0};
    divTrial = divShift[2*WIDTH:WIDTH] - {1'b0, bMagR};
    prNext   = (opR == MDU_DIV) ? ((pr[2*WIDTH] | ~divTrial[WIDTH]) ? {divTrial, divShift[WIDTH-1:1], 1'b1} : divShift)
             : FAST_MUL ? {1'b0, fastProd} : {1'b0, mulSum, pr[WIDTH-1:1]};
  end

  // FSM, step counter, operand latches and registered results
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= '0;
      pr     <= '0;
      aMagR  <= '0;
      bMagR  <= '0;
      aOrig  <= '0;
      opR    <= MDU_MUL;
      negRes <= 1'b0;
      negRem <= 1'b0;
      done_o <= 1'b0;
      hi_o   <= '0;
      lo_o   <= '0;
      dbz_o  <= 1'b0;
    end else begin
      done_o <= 1'b0;
      if (accept) begin
        state  <= RUN;
        cnt    <= '0;
        opR    <= op_i;
        aMagR  <= aMagIn;
        bMagR  <= bMagIn;
        aOrig  <= a_i;
        negRes <= aNegIn ^ bNegIn;
        negRem <= aNegIn;
        pr     <= {{(WIDTH + 1){1'b0}}, (op_i == MDU_DIV) ? aMagIn : bMagIn};
      end else if (state == RUN) begin
        if (cancel_i) begin
          state <= IDLE;
        end else begin
          pr  <= prNext;
          cnt <= cnt + 1'b1;
          if (lastStep) begin
            state  <= DONE;
            done_o <= 1'b1;
            dbz_o  <= dbzNow;
            hi_o   <= dbzNow ? aOrig : hiRes;
            lo_o   <= dbzNow ? '1 : loRes;
          end
        end
      end else begin
        state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: slow and fast-multiply instances checked every cycle against an arithmetic reference
module tb_mdu_iter;
  localparam int W = 32;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, op = 1'b0, sign = 1'b0, cancel = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic [1:0] busyV, doneV, dbzV;
  logic [W-1:0] hiV [2];
  logic [W-1:0] loV [2];
  int vec = 0, err = 0;
  int l0, l1;

  bit pend [2];
  int rem [2];
  logic [W-1:0] mHi [2], mLo [2], pHi [2], pLo [2];
  logic mDbz [2], pDbz [2], mDone [2];

  mdu_iter #(.WIDTH(W), .FAST_MUL(1'b0)) dut0 (
    .clk(clk), .rst(rst), .start_i(start), .op_i(op), .sign_i(sign), .a_i(a), .b_i(b), .cancel_i(cancel),
    .busy_o(busyV[0]), .done_o(doneV[0]), .hi_o(hiV[0]), .lo_o(loV[0]), .dbz_o(dbzV[0]));
  mdu_iter #(.WIDTH(W), .FAST_MUL(1'b1)) dut1 (
    .clk(clk), .rst(rst), .start_i(start), .op_i(op), .sign_i(sign), .a_i(a), .b_i(b), .cancel_i(cancel),
    .busy_o(busyV[1]), .done_o(doneV[1]), .hi_o(hiV[1]), .lo_o(loV[1]), .dbz_o(dbzV[1]));

  always #5 clk = ~clk;

  task automatic chk(input string n, input int d, input logic [63:0] act, input logic [63:0] exp);
    vec++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s dut%0d got %h want %h at %0t", n, d, act, exp, $time);
    end
  endtask

  function automatic void refOp(input logic o, input logic s, input logic [W-1:0] x, input logic [W-1:0] y,
                                output logic [W-1:0] h, output logic [W-1:0] l, output logic z);
    longint sx, sy, p;
    logic [63:0] u;
    z = 1'b0;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (!o) begin
      if (s) begin
        p = sx * sy;
        {h, l} = p;
      end else begin
        u = {32'b0, x} * {32'b0, y};
        {h, l} = u;
      end
    end else if (y == '0) begin
      h = x;
      l = '1;
      z = 1'b1;
    end else if (s) begin
      l = W'(sx / sy);
      h = W'(sx % sy);
    end else begin
      l = x / y;
      h = x % y;
    end
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  // reference: a launch completes W edges later (1 edge for a fast multiply) unless flushed first
  always @(posedge clk or negedge rst) begin
    for (int d = 0; d < 2; d++) begin
      logic [W-1:0] h, l;
      logic z;
      if (!rst) begin
        pend[d] <= 1'b0; rem[d] <= 0; mHi[d] <= '0; mLo[d] <= '0; mDbz[d] <= 1'b0; mDone[d] <= 1'b0;
      end else begin
        mDone[d] <= 1'b0;
        if (pend[d]) begin
          if (cancel) pend[d] <= 1'b0;
          else if (rem[d] == 1) begin
            pend[d] <= 1'b0; mDone[d] <= 1'b1; mHi[d] <= pHi[d]; mLo[d] <= pLo[d]; mDbz[d] <= pDbz[d];
          end else rem[d] <= rem[d] - 1;
        end else if (start && !cancel) begin
          refOp(op, sign, a, b, h, l, z);
          pend[d] <= 1'b1;
          rem[d]  <= (d == 1 && !op) ? 1 : W;
          pHi[d] <= h; pLo[d] <= l; pDbz[d] <= z;
        end
      end
    end
  end

  // every-cycle comparison of both instances against the reference
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      chk("done", d, doneV[d], mDone[d]);
      chk("busy", d, busyV[d], rst & (pend[d] | (start & ~cancel)));
      chk("hi", d, hiV[d], mHi[d]);
      chk("lo", d, loV[d], mLo[d]);
      chk("dbz", d, dbzV[d], mDbz[d]);
    end
  end

  task automatic runOp(input logic o, input logic s, input logic [W-1:0] x, input logic [W-1:0] y,
                       output int t0, output int t1);
    start = 1'b1; op = o; sign = s; a = x; b = y;
    @(posedge clk); #1 start = 1'b0;
    t0 = 0; t1 = 0;
    for (int k = 1; k <= 80 && (t0 == 0 || t1 == 0); k++) begin
      @(negedge clk);
      if (doneV[0] && t0 == 0) t0 = k;
      if (doneV[1] && t1 == 0) t1 = k;
    end
    if (t0 == 0 || t1 == 0) chk("timeout", 0, {t0[31:0], t1[31:0]}, 64'hFFFF_FFFF_FFFF_FFFF);
    @(posedge clk); #1;
  endtask

  initial begin
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_lo", 0, loV[0], 0);
    chk("rst_done", 0, doneV[0], 0);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    runOp(1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, l0, l1);
    chk("t1_lat", 0, l0, 33);
    chk("t1_fastlat", 1, l1, 2);
    chk("t1_prod", 0, {hiV[0], loV[0]}, 64'hFFFF_FFFE_0000_0001);
    runOp(1'b1, 1'b1, -32'sd7, 32'd2, l0, l1);
    chk("t2_sdiv", 0, {hiV[0], loV[0]}, 64'hFFFF_FFFF_FFFF_FFFD);
    runOp(1'b1, 1'b0, 32'd7, 32'd2, l0, l1);
    chk("t2_udiv", 0, {hiV[0], loV[0]}, 64'h0000_0001_0000_0003);
    runOp(1'b1, 1'b0, 32'h1234, 32'h0, l0, l1);
    chk("t3_lat", 0, l0, 33);
    chk("t3_dbz", 0, {dbzV[0], hiV[0], loV[0]}, {1'b1, 32'h1234, 32'hFFFF_FFFF});
    runOp(1'b0, 1'b0, 32'd3, 32'd4, l0, l1);
    chk("t3_clr", 0, {dbzV[0], loV[0]}, {1'b0, 32'd12});
    runOp(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, l0, l1);
    chk("t4_ovf", 0, {dbzV[0], hiV[0], loV[0]}, {1'b0, 32'h0, 32'h8000_0000});
    runOp(1'b0, 1'b0, 32'd3, 32'd4, l0, l1);
    start = 1'b1; op = 1'b1; sign = 1'b0; a = 32'd100; b = 32'd7;
    repeat (10) begin @(posedge clk); #1 a = $urandom; end
    cancel = 1'b1;
    @(posedge clk); #1 cancel = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("t5_busy", 0, busyV[0], 0);
    chk("t5_keep", 0, {hiV[0], loV[0]}, {32'd0, 32'd12});
    l0 = 0;
    repeat (40) begin @(negedge clk); if (doneV[0]) l0++; end
    chk("t5_nodone", 0, l0, 0);
    @(posedge clk); #1;
    start = 1'b1; op = 1'b0; sign = 1'b1; a = -32'sd5; b = 32'd6;
    @(posedge clk); #1 a = 32'd7; b = 32'd8;
    @(posedge clk); #1;
    @(negedge clk);
    chk("t6_done", 1, {doneV[1], busyV[1]}, 2'b11);
    chk("t6_prod", 1, {hiV[1], loV[1]}, 64'hFFFF_FFFF_FFFF_FFE2);
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("t6_b2b", 1, {doneV[1], loV[1]}, {1'b1, 32'd56});
    @(posedge clk); #3 rst = 1'b0;
    #1;
    chk("t6_rst0", 0, {busyV[0], doneV[0], dbzV[0], hiV[0], loV[0]}, 0);
    chk("t6_rst1", 1, {busyV[1], doneV[1], dbzV[1], hiV[1], loV[1]}, 0);
    @(posedge clk); #1 rst = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      start = ($urandom_range(0, 5) == 0); op = $urandom_range(0, 1); sign = $urandom_range(0, 1);
      a = pick(); b = pick(); cancel = ($urandom_range(0, 29) == 0);
      @(posedge clk); #1;
    end
    start = 1'b0; cancel = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
